// File: rtl/core_pkg.sv
// Shared widths, NOP encoding and owner encoding for the uop issue arbiter.
package core_pkg;

  localparam int unsigned UOP_W  = 20;
  localparam int unsigned DATA_W = 16;

  // bit11: no reg_wr, bits10:9: no mar_wr; no mem access, no flag update
  localparam logic [UOP_W-1:0] UOP_NOP = UOP_W'(20'h00E00);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_M = 2'd1,
    ST_OWN_S = 2'd2
  } owner_e;

  typedef struct packed {
    logic [UOP_W-1:0]  uop;
    logic [DATA_W-1:0] temp_a;
    logic [DATA_W-1:0] temp_b;
    logic              next_sched;
    logic              next_main;
  } slot_t;

  localparam slot_t SLOT_NOP = '{
    uop:        UOP_NOP,
    temp_a:     '0,
    temp_b:     '0,
    next_sched: 1'b0,
    next_main:  1'b0
  };

endpackage

// File: rtl/uop_issue_arbiter.sv
// Shares the execute-stage issue slot between the main and sched uop streams,
// granting whole sequences atomically and bounding how long main can starve.
module uop_issue_arbiter
  import core_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic              stop,
  input  logic              flush,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [UOP_W-1:0]  m_uop,
  input  logic [DATA_W-1:0] m_temp,
  input  logic              m_last,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [UOP_W-1:0]  s_uop,
  input  logic [DATA_W-1:0] s_temp,
  input  logic              s_last,
  output logic [UOP_W-1:0]  uop_next,
  output logic [DATA_W-1:0] temp_a,
  output logic [DATA_W-1:0] temp_b,
  output logic              next_sched,
  output logic              next_main,
  output logic [1:0]        owner
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  owner_e           r_state;
  owner_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  slot_t            r_hold;
  slot_t            w_slot;
  logic             w_sel_m;
  logic             w_sel_s;
  logic             w_go;

  // State, starvation counter and replay registers
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hold  <= SLOT_NOP;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (!stop) begin
        r_hold <= w_slot;
      end
    end
  end

  // Stream selection, slot mux and next state
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_slot      = r_hold;
    w_sel_m     = 1'b0;
    w_sel_s     = 1'b0;
    m_ready     = 1'b0;
    s_ready     = 1'b0;
    w_go        = ~a_rst & ~stop & ~flush;

    case (r_state)
      ST_OWN_M: w_sel_m = 1'b1;
      ST_OWN_S: w_sel_s = 1'b1;
      default: begin
        // main only overrides sched once the starvation budget is spent
        if (s_valid && !(m_valid && (r_cnt == CNT_MAX))) begin
          w_sel_s = 1'b1;
        end else if (m_valid) begin
          w_sel_m = 1'b1;
        end
      end
    endcase

    m_ready = w_go & w_sel_m;
    s_ready = w_go & w_sel_s;

    if (!stop) begin
      w_slot = SLOT_NOP;
      if (m_valid && m_ready) begin
        w_slot.uop       = m_uop;
        w_slot.temp_a    = m_temp;
        w_slot.next_main = 1'b1;
        w_state_nxt      = m_last ? ST_IDLE : ST_OWN_M;
        if (r_state == ST_IDLE) begin
          w_cnt_nxt = '0;
        end
      end else if (s_valid && s_ready) begin
        w_slot.uop        = s_uop;
        w_slot.temp_b     = s_temp;
        w_slot.next_sched = 1'b1;
        w_state_nxt       = s_last ? ST_IDLE : ST_OWN_S;
        if ((r_state == ST_IDLE) && m_valid && (r_cnt != CNT_MAX)) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
    end

    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end
  end

  assign uop_next   = w_slot.uop;
  assign temp_a     = w_slot.temp_a;
  assign temp_b     = w_slot.temp_b;
  assign next_sched = w_slot.next_sched;
  assign next_main  = w_slot.next_main;
  assign owner      = r_state;

endmodule

// File: tb/tb_uop_issue_arbiter.sv
// Randomized and scenario bench for uop_issue_arbiter against a behavioural model.
module tb_uop_issue_arbiter;
  import core_pkg::*;

  localparam int unsigned STARVE = 4;
  localparam logic [UOP_W-1:0] NOP_C = 20'h00E00;

  logic              clk = 1'b0;
  logic              a_rst, stop, flush;
  logic              m_valid, m_ready, m_last;
  logic              s_valid, s_ready, s_last;
  logic [UOP_W-1:0]  m_uop, s_uop, uop_next;
  logic [DATA_W-1:0] m_temp, s_temp, temp_a, temp_b;
  logic              next_sched, next_main;
  logic [1:0]        owner;

  uop_issue_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clk(clk), .a_rst(a_rst), .stop(stop), .flush(flush),
    .m_valid(m_valid), .m_ready(m_ready), .m_uop(m_uop), .m_temp(m_temp), .m_last(m_last),
    .s_valid(s_valid), .s_ready(s_ready), .s_uop(s_uop), .s_temp(s_temp), .s_last(s_last),
    .uop_next(uop_next), .temp_a(temp_a), .temp_b(temp_b),
    .next_sched(next_sched), .next_main(next_main), .owner(owner)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Model: who holds the slot (0 none, 1 main, 2 sched), sched grants in a row
  // while main waited, and the last slot shown to the execute stage.
  int                md_owner  = 0;
  int                md_streak = 0;
  logic [UOP_W-1:0]  md_h_uop  = NOP_C;
  logic [DATA_W-1:0] md_h_ta   = '0;
  logic [DATA_W-1:0] md_h_tb   = '0;
  logic              md_h_ns   = 1'b0;
  logic              md_h_nm   = 1'b0;

  logic [UOP_W-1:0]  ob_uop;
  logic [DATA_W-1:0] ob_ta, ob_tb;
  logic              ob_ns, ob_nm, ob_mr, ob_sr;
  logic [1:0]        ob_owner;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    md_owner  = 0;
    md_streak = 0;
    md_h_uop  = NOP_C;
    md_h_ta   = '0;
    md_h_tb   = '0;
    md_h_ns   = 1'b0;
    md_h_nm   = 1'b0;
  endtask

  // One cycle: inputs were set after the falling edge; compare mid-cycle, then advance model.
  task automatic tick();
    int                who;
    logic              go, mf, sf;
    logic [UOP_W-1:0]  e_uop;
    logic [DATA_W-1:0] e_ta, e_tb;
    logic              e_ns, e_nm;
    #1;
    if (a_rst) model_reset();
    if (md_owner != 0) who = md_owner;
    else if (s_valid && !(m_valid && md_streak >= STARVE)) who = 2;
    else if (m_valid) who = 1;
    else who = 0;
    go = !a_rst && !stop && !flush;
    mf = go && who == 1 && m_valid;
    sf = go && who == 2 && s_valid;
    if (stop || a_rst) begin
      e_uop = md_h_uop; e_ta = md_h_ta; e_tb = md_h_tb; e_ns = md_h_ns; e_nm = md_h_nm;
    end else if (mf) begin
      e_uop = m_uop; e_ta = m_temp; e_tb = '0; e_ns = 1'b0; e_nm = 1'b1;
    end else if (sf) begin
      e_uop = s_uop; e_ta = '0; e_tb = s_temp; e_ns = 1'b1; e_nm = 1'b0;
    end else begin
      e_uop = NOP_C; e_ta = '0; e_tb = '0; e_ns = 1'b0; e_nm = 1'b0;
    end
    check("m_ready", 32'(m_ready), 32'(go && who == 1));
    check("s_ready", 32'(s_ready), 32'(go && who == 2));
    check("uop_next", 32'(uop_next), 32'(e_uop));
    check("temp_a", 32'(temp_a), 32'(e_ta));
    check("temp_b", 32'(temp_b), 32'(e_tb));
    check("next_sched", 32'(next_sched), 32'(e_ns));
    check("next_main", 32'(next_main), 32'(e_nm));
    check("owner", 32'(owner), 32'(md_owner));
    ob_uop = uop_next; ob_ta = temp_a; ob_tb = temp_b; ob_ns = next_sched;
    ob_nm = next_main; ob_mr = m_ready; ob_sr = s_ready; ob_owner = owner;
    @(posedge clk);
    if (!a_rst) begin
      if (flush) begin
        md_owner = 0; md_streak = 0;
      end else if (mf) begin
        if (md_owner == 0) md_streak = 0;
        md_owner = m_last ? 0 : 1;
      end else if (sf) begin
        if (md_owner == 0 && m_valid && md_streak < STARVE) md_streak++;
        md_owner = s_last ? 0 : 2;
      end
      if (!stop) begin
        md_h_uop = e_uop; md_h_ta = e_ta; md_h_tb = e_tb; md_h_ns = e_ns; md_h_nm = e_nm;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [UOP_W-1:0] u_hold;
    a_rst = 1'b1; stop = 1'b0; flush = 1'b0;
    m_valid = 1'b1; m_last = 1'b0; m_uop = 20'h12345; m_temp = 16'hA1A1;
    s_valid = 1'b0; s_last = 1'b0; s_uop = 20'h0; s_temp = 16'h0;
    @(negedge clk);

    // reset holds a NOP bubble with main waiting; release lets main fire at once
    tick();
    check("rst_m_ready", 32'(ob_mr), 32'd0);
    check("rst_uop_nop", 32'(ob_uop), 32'(NOP_C));
    check("rst_owner", 32'(ob_owner), 32'd0);
    a_rst = 1'b0;
    tick();
    check("rel_main_fires", 32'(ob_nm), 32'd1);
    check("rel_main_uop", 32'(ob_uop), 32'h12345);

    // 3-uop main sequence stays contiguous while sched waits
    s_valid = 1'b1; s_last = 1'b1; s_uop = 20'h54321; s_temp = 16'h5B5B;
    m_uop = 20'h22222;
    tick();
    check("seq_main2", 32'(ob_nm), 32'd1);
    check("seq_sched_wait2", 32'(ob_sr), 32'd0);
    m_uop = 20'h33333; m_last = 1'b1;
    tick();
    check("seq_main3", 32'(ob_nm), 32'd1);
    check("seq_sched_wait3", 32'(ob_sr), 32'd0);
    m_valid = 1'b0;
    tick();
    check("seq_sched_next", 32'(ob_ns), 32'd1);

    // starvation bound: S,S,S,S,M repeating with single-uop sequences
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0; m_valid = 1'b1; m_last = 1'b1; s_valid = 1'b1; s_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      m_temp = 16'($urandom); s_temp = 16'($urandom);
      m_uop = 20'($urandom); s_uop = 20'($urandom);
      tick();
      check("starve_pat", 32'(ob_ns), 32'((i % 5) != 4));
      if ((i % 5) != 4) check("starve_tb", 32'(ob_tb), 32'(s_temp));
      else check("starve_ta", 32'(ob_ta), 32'(m_temp));
    end

    // stall mid main sequence replays the last uop
    s_valid = 1'b0; m_last = 1'b0; m_uop = 20'h0AAA1;
    tick();
    m_uop = 20'h0AAA2; u_hold = m_uop;
    tick();
    stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_uop = 20'($urandom);
      tick();
      check("stop_replay", 32'(ob_uop), 32'(u_hold));
      check("stop_next_main", 32'(ob_nm), 32'd1);
      check("stop_owner", 32'(ob_owner), 32'd1);
      check("stop_m_ready", 32'(ob_mr), 32'd0);
    end
    stop = 1'b0; m_uop = 20'h0AAA3; m_last = 1'b1;
    tick();
    check("stop_release", 32'(ob_uop), 32'h0AAA3);

    // flush on the sched last uop aborts it; it is re-presented and fires
    m_valid = 1'b0; s_valid = 1'b1; s_last = 1'b0; s_uop = 20'h0BBB1;
    tick();
    s_last = 1'b1; s_uop = 20'h0BBB2; flush = 1'b1;
    tick();
    check("flush_s_ready", 32'(ob_sr), 32'd0);
    check("flush_bubble", 32'(ob_uop), 32'(NOP_C));
    flush = 1'b0;
    tick();
    check("flush_owner_idle", 32'(ob_owner), 32'd0);
    check("flush_refire", 32'(ob_uop), 32'h0BBB2);

    // reset mid sched sequence, then main wins idle
    s_last = 1'b0;
    tick();
    a_rst = 1'b1;
    tick();
    check("rst_mid_owner", 32'(ob_owner), 32'd0);
    check("rst_mid_nop", 32'(ob_uop), 32'(NOP_C));
    a_rst = 1'b0; s_valid = 1'b0; m_valid = 1'b1; m_uop = 20'h0CCC1;
    tick();
    check("rst_mid_main", 32'(ob_nm), 32'd1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      a_rst   = ($urandom_range(63) == 0);
      stop    = ($urandom_range(5) == 0);
      flush   = ($urandom_range(15) == 0);
      m_valid = ($urandom_range(3) != 0);
      s_valid = ($urandom_range(3) != 0);
      m_last  = ($urandom_range(2) == 0);
      s_last  = ($urandom_range(2) == 0);
      m_uop   = 20'($urandom); s_uop  = 20'($urandom);
      m_temp  = 16'($urandom); s_temp = 16'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
